// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and constants.
// Used by the fetch queue FSM and its entry storage.
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic {
      FETCH     = 1'b0,
      MISS_WAIT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular entry store for the fetch queue.
// Synchronous write, combinational head read, flush clears pointers.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = $bits(fetch_entry_t)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [W-1:0]           wr_data,
   input  logic                   rd_en,
   output logic [W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;
   logic          wr_ok, rd_ok;

   assign rd_ok = rd_en && (count_q != '0);
   assign wr_ok = wr_en && ((count_q != FULL) || rd_ok);

   // Storage carries no reset; head data is don't-care while empty.
   always_ff @(posedge clk) begin
      if (wr_ok && !flush) begin
         mem[tail_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (wr_ok) tail_q <= tail_q + 1'b1;
         if (rd_ok) head_q <= head_q + 1'b1;
         unique case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_data = mem[head_q];
   assign count   = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch PC/miss FSM feeding a small decoupling queue.
// Redirect flushes everything and reloads the word-aligned target.
module instr_fetch_queue
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [INSTR_W-1:0]     instr_f,
   input  logic                   hit_miss,
   input  logic                   countdone,
   input  logic                   redirect,
   input  logic [XLEN-1:0]        redirect_pc,
   input  logic                   deq_ready,
   output logic [XLEN-1:0]        pc_f,
   output logic                   deq_valid,
   output logic [INSTR_W-1:0]     deq_instr,
   output logic [XLEN-1:0]        deq_pc,
   output logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            enq, deq, room;
   fetch_entry_t    wr_entry, rd_entry;
   logic            unused_pc_lsb;

   assign unused_pc_lsb = ^redirect_pc[1:0];

   assign deq_valid = (count != '0);
   assign deq       = deq_valid && deq_ready && !redirect;
   assign room      = (count != FULL) || deq;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      enq     = 1'b0;
      if (redirect) begin
         state_d = FETCH;
         pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      end else begin
         unique case (state_q)
            FETCH: begin
               if (!hit_miss) begin
                  state_d = MISS_WAIT;
               end else if (room) begin
                  enq  = 1'b1;
                  pc_d = pc_q + PC_INC;
               end
            end
            MISS_WAIT: begin
               if (countdone) state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   assign wr_entry = '{pc: pc_q, instr: instr_f};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (redirect),
      .wr_en   (enq),
      .wr_data (wr_entry),
      .rd_en   (deq),
      .rd_data (rd_entry),
      .count   (count)
   );

   assign pc_f      = pc_q;
   assign deq_pc    = rd_entry.pc;
   assign deq_instr = rd_entry.instr;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue.
// Directed scenarios plus random traffic against a queue-based model.
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] instr_f = '0;
   logic        hit_miss = 1'b0;
   logic        countdone = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        deq_ready = 1'b0;
   logic [31:0] pc_f;
   logic        deq_valid;
   logic [31:0] deq_instr;
   logic [31:0] deq_pc;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] mq[$];
   logic [31:0] mpc;
   bit          mmiss;

   instr_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .instr_f     (instr_f),
      .hit_miss    (hit_miss),
      .countdone   (countdone),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .deq_ready   (deq_ready),
      .pc_f        (pc_f),
      .deq_valid   (deq_valid),
      .deq_instr   (deq_instr),
      .deq_pc      (deq_pc),
      .count       (count)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs and advance the reference model at the edge.
   task automatic step(input logic hm, input logic [31:0] ins,
                       input logic cd, input logic rd,
                       input logic [31:0] rpc, input logic dr);
      bit deq, enq;
      hit_miss    = hm;
      instr_f     = ins;
      countdone   = cd;
      redirect    = rd;
      redirect_pc = rpc;
      deq_ready   = dr;
      @(posedge clk);
      if (rd) begin
         mq.delete();
         mpc   = {rpc[31:2], 2'b00};
         mmiss = 1'b0;
      end else begin
         deq = (mq.size() > 0) && dr;
         enq = !mmiss && hm && ((mq.size() < DEPTH) || deq);
         if (mmiss) begin
            if (cd) mmiss = 1'b0;
         end else if (!hm) begin
            mmiss = 1'b1;
         end
         if (deq) void'(mq.pop_front());
         if (enq) begin
            mq.push_back({mpc, ins});
            mpc = mpc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic hit(input logic dr);
      step(1'b1, $urandom, 1'b0, 1'b0, 32'h0, dr);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      hit_miss = 1'b0; countdone = 1'b0; redirect = 1'b0; deq_ready = 1'b0;
      mq.delete();
      mpc   = RESET_PC;
      mmiss = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (pc_f !== RESET_PC) begin
         $display("FAIL reset_pc: got %h want %h", pc_f, RESET_PC); n_err++;
      end
      n_cmp++;
      if (count !== 3'd0 || deq_valid !== 1'b0) begin
         $display("FAIL reset_empty: count %0d valid %b want 0 0", count, deq_valid);
         n_err++;
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         hit(1'b1);
         n_cmp++;
         if (pc_f !== 32'(4 * (i + 1)) || deq_valid !== 1'b1 ||
             deq_pc !== 32'(4 * i) || count !== 3'd1) begin
            $display("FAIL stream_%0d: pc %h deq_pc %h valid %b count %0d want %h %h 1 1",
                     i, pc_f, deq_pc, deq_valid, count, 4 * (i + 1), 4 * i);
            n_err++;
         end
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 6; i++) hit(1'b0);
      n_cmp++;
      if (count !== 3'd4 || pc_f !== 32'h10) begin
         $display("FAIL full_hold: count %0d pc %h want 4 00000010", count, pc_f);
         n_err++;
      end
      hit(1'b1);
      n_cmp++;
      if (count !== 3'd4 || pc_f !== 32'h14 || deq_pc !== 32'h4) begin
         $display("FAIL full_enq_deq: count %0d pc %h deq_pc %h want 4 14 4",
                  count, pc_f, deq_pc);
         n_err++;
      end
      n_cmp++;
      if (deq_instr !== mq[0][31:0]) begin
         $display("FAIL full_instr: got %h want %h", deq_instr, mq[0][31:0]);
         n_err++;
      end
   endtask

   task automatic test_miss();
      do_reset();
      for (int i = 0; i < 8; i++) hit(1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'($urandom), $urandom, 1'b0, 1'b0, 32'h0, 1'b1);
         n_cmp++;
         if (pc_f !== 32'h20 || count !== 3'd0) begin
            $display("FAIL miss_hold_%0d: pc %h count %0d want 20 0", i, pc_f, count);
            n_err++;
         end
      end
      step(1'b1, $urandom, 1'b1, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (pc_f !== 32'h20 || count !== 3'd0) begin
         $display("FAIL miss_done: pc %h count %0d want 20 0", pc_f, count);
         n_err++;
      end
      step(1'b1, 32'hCAFE_0020, 1'b1, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (deq_valid !== 1'b1 || deq_pc !== 32'h20 || deq_instr !== 32'hCAFE_0020 ||
          pc_f !== 32'h24) begin
         $display("FAIL miss_refetch: valid %b deq_pc %h instr %h pc %h want 1 20 cafe0020 24",
                  deq_valid, deq_pc, deq_instr, pc_f);
         n_err++;
      end
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 3; i++) hit(1'b0);
      step(1'b1, $urandom, 1'b0, 1'b1, 32'h103, 1'b1);
      n_cmp++;
      if (count !== 3'd0 || deq_valid !== 1'b0 || pc_f !== 32'h100) begin
         $display("FAIL redirect: count %0d valid %b pc %h want 0 0 100",
                  count, deq_valid, pc_f);
         n_err++;
      end
   endtask

   task automatic test_redirect_miss();
      do_reset();
      hit(1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, $urandom, 1'b1, 1'b1, 32'h200, 1'b1);
      n_cmp++;
      if (pc_f !== 32'h200 || count !== 3'd0) begin
         $display("FAIL redir_miss: pc %h count %0d want 200 0", pc_f, count);
         n_err++;
      end
      hit(1'b0);
      n_cmp++;
      if (count !== 3'd1 || deq_pc !== 32'h200 || pc_f !== 32'h204) begin
         $display("FAIL redir_miss_fetch: count %0d deq_pc %h pc %h want 1 200 204",
                  count, deq_pc, pc_f);
         n_err++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0);
      hit(1'b1);
      hit(1'b1);
      n_cmp++;
      if (pc_f !== 32'h0 || deq_pc !== 32'hFFFF_FFFC) begin
         $display("FAIL pc_wrap: pc %h deq_pc %h want 0 fffffffc", pc_f, deq_pc);
         n_err++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      hit(1'b0);
      hit(1'b0);
      #3;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (deq_valid !== 1'b0 || count !== 3'd0 || pc_f !== RESET_PC) begin
         $display("FAIL async_reset: valid %b count %0d pc %h want 0 0 %h",
                  deq_valid, count, pc_f, RESET_PC);
         n_err++;
      end
      do_reset();
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      do_reset();
      step(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 1'b0);
      n_cmp++;
      if (count !== 3'd1 || pc_f !== RESET_PC + 32'd4) begin
         $display("FAIL reset_abandon_miss: count %0d pc %h want 1 %h",
                  count, pc_f, RESET_PC + 32'd4);
         n_err++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 8), $urandom, ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 9) < 6));
         n_cmp++;
         if (pc_f !== mpc || count !== 3'(mq.size()) ||
             deq_valid !== (mq.size() != 0)) begin
            $display("FAIL rand_state_%0d: pc %h count %0d valid %b want %h %0d %b",
                     i, pc_f, count, deq_valid, mpc, mq.size(), mq.size() != 0);
            n_err++;
         end else if (mq.size() != 0) begin
            n_cmp++;
            if ({deq_pc, deq_instr} !== mq[0]) begin
               $display("FAIL rand_head_%0d: got %h want %h",
                        i, {deq_pc, deq_instr}, mq[0]);
               n_err++;
            end
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_stream();
      test_full();
      test_miss();
      test_redirect();
      test_redirect_miss();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count (power of 2, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value after reset.
REQ-003 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 instr_f  in  32  instruction returned by the instruction memory for the current pc_f.
REQ-006 hit_miss  in  1  1 = instr_f is valid this cycle; 0 = cache miss.
REQ-007 countdone  in  1  single-cycle pulse marking refill complete.
REQ-008 redirect  in  1  branch/jump taken; flushes the queue and reloads the PC.
REQ-009 redirect_pc  in  32  new fetch address, qualified by redirect.
REQ-010 deq_ready  in  1  decode stage accepts the head entry.
REQ-011 pc_f  out  32  fetch address driven to the instruction memory.
REQ-012 deq_valid  out  1  head entry is valid.
REQ-013 deq_instr  out  32  head instruction.
REQ-014 deq_pc  out  32  PC of the head instruction.
REQ-015 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 The state machine SHALL have two states: FETCH and MISS_WAIT.
REQ-017 In FETCH with hit_miss=0 and redirect=0, the block SHALL enqueue nothing, hold pc_f, and enter MISS_WAIT.
REQ-018 In MISS_WAIT, the block SHALL hold pc_f, enqueue nothing, and return to FETCH on the edge where countdone=1.
REQ-019 In FETCH, countdone SHALL be ignored.
REQ-020 Enqueue SHALL occur when state=FETCH, hit_miss=1, redirect=0, and (count<DEPTH or a dequeue occurs in the same cycle).
REQ-021 Each enqueue SHALL write {pc_f, instr_f} at the tail and advance pc_f by 4 on the same edge.
REQ-022 When the enqueue condition fails only because the queue is full, pc_f SHALL hold and the state SHALL remain FETCH.
REQ-023 A dequeue SHALL occur when deq_valid=1 and deq_ready=1, advancing the head.
REQ-024 deq_valid SHALL equal (count!=0); deq_instr and deq_pc SHALL come combinationally from the head entry, with zero added latency from storage.
REQ-025 Minimum latency from enqueue to deq_valid SHALL be one cycle.
REQ-026 Simultaneous enqueue and dequeue SHALL leave count unchanged, including when full or when count=1.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-028 redirect=1 SHALL have priority over every other event: count:=0, head=tail:=0, pc_f:={redirect_pc[31:2],2'b00}, state:=FETCH.
REQ-029 On a redirect cycle, no enqueue or dequeue SHALL take effect, whatever the values of hit_miss, deq_ready, or countdone.
REQ-030 pc_f addition SHALL be modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0).

Reset
REQ-031 reset_n=0 SHALL immediately set pc_f=RESET_PC, state=FETCH, count=0, pointers=0, and deq_valid=0.
REQ-032 Queue storage SHALL not require reset; deq_instr and deq_pc SHALL be don't-care while deq_valid=0.
REQ-033 Reset asserted in MISS_WAIT SHALL abandon the miss; a countdone pulse after reset release while in FETCH SHALL be ignored.

Structure
REQ-034 The state enum (FETCH, MISS_WAIT), the instruction width of 32, and the PC increment of 4 SHALL live in the shared fetch package.
REQ-035 Storage SHALL be one sub-module, fetch_fifo: parameterized, synchronous write, combinational read, with flush input.
REQ-036 The FSM and PC register SHALL be in instr_fetch_queue.

Verification
REQ-037 Reset, then hit_miss=1 and deq_ready=1 for 4 cycles -> pc_f goes 0,4,8,C,10; deq_pc 0,4,8,C appears one cycle after each fetch.
REQ-038 deq_ready=0 with hit_miss=1 for 6 cycles (DEPTH=4) -> count=4, pc_f holds at 32'h10; deq_ready=1 for one cycle -> dequeue and enqueue together, count stays 4.
REQ-039 hit_miss=0 at pc_f=32'h20 -> MISS_WAIT, pc_f holds 32'h20 for 5 cycles; countdone pulse -> FETCH; next hit enqueues PC 32'h20.
REQ-040 redirect=1, redirect_pc=32'h103 with count=3 and hit_miss=1 -> next cycle count=0, deq_valid=0, pc_f=32'h100.
REQ-041 redirect during MISS_WAIT, with countdone asserted in the same cycle -> state=FETCH, pc_f=redirect target, no enqueue.
REQ-042 reset_n pulsed low mid-cycle while count=2 -> deq_valid falls immediately; pc_f=RESET_PC before the next clk edge.
